// File: rtl/pc_fetch_controller_if.sv
// pc_fetch_controller_if
//   Groups every non-clock signal of the fetch controller.
//   Controller-facing view: modport master. Environment view (pc_register,
//   instruction memory, hazard/branch/exception logic): modport slave.
//
//   Handshake: imem_req is held high while the controller waits for an
//   instruction at imem_addr. The memory answers by raising imem_ready in
//   the cycle the instruction is returned. The transfer completes in any
//   cycle where imem_req and imem_ready are both high. imem_addr stays
//   stable until that cycle.
//
//   Signals
//     pc_current    pc_register.pc_out
//     pc_address    next PC, to pc_register.pc_address
//     pc_enable     load strobe, to pc_register.enable
//     imem_req      fetch request
//     imem_addr     fetch address (always pc_current)
//     imem_ready    memory returns the instruction this cycle
//     fetch_valid   returned instruction is valid (not squashed)
//     stall         decode cannot accept a new instruction
//     branch_taken  branch redirect pulse, target in branch_target
//     jump          jump redirect pulse, target in jump_target
//     exception     exception pulse
//     epc           PC captured at the last exception
//     dbg_state     current FSM state encoding (debug/observability)
interface pc_fetch_controller_if;
    logic [31:0] pc_current;
    logic [31:0] pc_address;
    logic        pc_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        fetch_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic [31:0] epc;
    logic [1:0]  dbg_state;

    modport master (
        input  pc_current,
        output pc_address,
        output pc_enable,
        output imem_req,
        output imem_addr,
        input  imem_ready,
        output fetch_valid,
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  jump,
        input  jump_target,
        input  exception,
        output epc,
        output dbg_state
    );

    modport slave (
        output pc_current,
        input  pc_address,
        input  pc_enable,
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        input  fetch_valid,
        output stall,
        output branch_taken,
        output branch_target,
        output jump,
        output jump_target,
        output exception,
        input  epc,
        input  dbg_state
    );
endinterface

// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller
//   Sequences the external pc_register for the MIPS fetch stage: loads the
//   reset vector, issues instruction-memory requests at the current PC,
//   applies decode stalls and selects the next PC from exception, jump,
//   branch, a pending (deferred) redirect or sequential PC+4.
//
//   Ports
//     clock  system clock, rising edge
//     reset  synchronous, active-high
//     bus    pc_fetch_controller_if.master (see interface header)
//
//   FSM: BOOT -> REQ <-> HOLD. BOOT loads RESET_VECTOR (pc_register's own
//   reset value is never relied on). REQ waits for imem_ready and advances
//   the PC once per returned instruction unless decode stalls. HOLD parks
//   with no request until the stall clears or a redirect arrives.
module pc_fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic                     clock,
    input  logic                     reset,
    pc_fetch_controller_if.master    bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Redirect remembered across cycles in which the PC could not move.
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        pend_is_exc;

    logic        redirect_now;
    logic [31:0] redirect_target;
    logic [31:0] next_pc;
    logic        use_next_pc;   // this cycle loads next_pc into pc_register
    logic        pc_enable_c;
    logic [31:0] pc_address_c;
    logic        imem_req_c;

    // ------------------------------------------------------------------
    // Next-PC selection. Targets are word-aligned by clearing bits [1:0];
    // the sequential increment wraps naturally at 2^32.
    // ------------------------------------------------------------------
    always_comb begin
        redirect_now    = bus.exception | bus.jump | bus.branch_taken;
        redirect_target = {bus.branch_target[31:2], 2'b00};
        if (bus.exception) begin
            redirect_target = {EXC_VECTOR[31:2], 2'b00};
        end else if (bus.jump) begin
            redirect_target = {bus.jump_target[31:2], 2'b00};
        end

        if (redirect_now) begin
            next_pc = redirect_target;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end else begin
            next_pc = bus.pc_current + 32'd4;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        use_next_pc  = 1'b0;
        pc_enable_c  = 1'b0;
        pc_address_c = next_pc;
        imem_req_c   = 1'b0;

        case (state)
            BOOT: begin
                pc_enable_c  = 1'b1;
                pc_address_c = RESET_VECTOR;
                state_next   = REQ;
            end
            REQ: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    if (bus.stall) begin
                        state_next = HOLD;
                    end else begin
                        use_next_pc = 1'b1;
                    end
                end
            end
            HOLD: begin
                // A redirect wins over the stall: the instruction parked in
                // decode is on the wrong path anyway.
                if (!bus.stall || redirect_now) begin
                    use_next_pc = 1'b1;
                    state_next  = REQ;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase

        if (use_next_pc) begin
            pc_enable_c = 1'b1;
        end

        if (reset) begin
            state_next   = BOOT;
            use_next_pc  = 1'b0;
            pc_enable_c  = 1'b0;
            pc_address_c = RESET_VECTOR;
            imem_req_c   = 1'b0;
        end
    end

    assign bus.pc_enable  = pc_enable_c;
    assign bus.pc_address = pc_address_c;
    assign bus.imem_req   = imem_req_c;
    assign bus.imem_addr  = bus.pc_current;
    assign bus.dbg_state  = state;

    // An instruction returned while any redirect is live or pending is on
    // the wrong path; it is squashed but the FSM still advances.
    assign bus.fetch_valid = (state == REQ) & bus.imem_ready & ~redirect_now
                           & ~pend_valid & ~reset;

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Pending redirect. Captured when a redirect arrives in a cycle that
    // does not load next_pc (REQ waiting or stalling, or BOOT, which loads
    // the reset vector instead). A pending exception is sticky against
    // later jumps/branches. Consumed by the next next_pc load.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
            pend_is_exc <= 1'b0;
        end else if (use_next_pc) begin
            pend_valid  <= 1'b0;
            pend_is_exc <= 1'b0;
        end else if (redirect_now) begin
            if (!(pend_valid && pend_is_exc && !bus.exception)) begin
                pend_valid  <= 1'b1;
                pend_target <= redirect_target;
                pend_is_exc <= bus.exception;
            end
        end
    end

    // ------------------------------------------------------------------
    // Exception PC capture.
    // ------------------------------------------------------------------
    logic [31:0] epc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            epc_q <= 32'd0;
        end else if (bus.exception) begin
            epc_q <= bus.pc_current;
        end
    end

    assign bus.epc = epc_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// tb_pc_fetch_controller
//   Directed, table-driven bench for pc_fetch_controller. A small
//   pc_register model closes the loop (pc_current follows pc_address on
//   pc_enable). Each vector is driven on the falling edge and checked 1ns
//   later, before the next rising edge.
module tb_pc_fetch_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    pc_fetch_controller_if bus ();

    pc_fetch_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // pc_register model with a bench-only override path for corner cases.
    logic [31:0] pc_reg    = 32'h1234_5678;
    logic        force_pc  = 1'b0;
    logic [31:0] force_val = 32'd0;

    always @(posedge clock) begin
        if (force_pc) begin
            pc_reg <= force_val;
        end else if (bus.pc_enable) begin
            pc_reg <= bus.pc_address;
        end
    end

    assign bus.pc_current = pc_reg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        stl;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        ex;
        logic        en;
        logic [31:0] addr;
        logic        req;
        logic        fv;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic rdy, input logic stl,
        input logic br, input logic [31:0] bt,
        input logic jp, input logic [31:0] jt, input logic ex,
        input logic en, input logic [31:0] addr, input logic req,
        input logic fv, input logic [31:0] pc, input logic [31:0] epc,
        input logic [1:0] st);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.stl = stl; v.br = br; v.bt = bt;
        v.jp = jp; v.jt = jt; v.ex = ex; v.en = en; v.addr = addr;
        v.req = req; v.fv = fv; v.pc = pc; v.epc = epc; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        @(negedge clock);
        force_pc          = 1'b0;
        reset             = v.rst;
        bus.imem_ready    = v.rdy;
        bus.stall         = v.stl;
        bus.branch_taken  = v.br;
        bus.branch_target = v.bt;
        bus.jump          = v.jp;
        bus.jump_target   = v.jt;
        bus.exception     = v.ex;
        #1;
        chk({tag, " pc_enable"},   {31'd0, bus.pc_enable},   {31'd0, v.en});
        // pc_address is only meaningful when loaded or under reset.
        if (v.en || v.rst) begin
            chk({tag, " pc_address"}, bus.pc_address, v.addr);
        end
        chk({tag, " imem_req"},    {31'd0, bus.imem_req},    {31'd0, v.req});
        chk({tag, " imem_addr"},   bus.imem_addr,            v.pc);
        chk({tag, " fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, v.fv});
        chk({tag, " epc"},         bus.epc,                  v.epc);
        chk({tag, " state"},       {30'd0, bus.dbg_state},   {30'd0, v.st});
    endtask

    localparam logic [31:0] EPC1 = 32'h0040_000C;
    localparam logic [31:0] EPC2 = 32'h8000_0184;

    initial begin
        bus.imem_ready    = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        bus.jump          = 1'b0;
        bus.jump_target   = 32'd0;
        bus.exception     = 1'b0;

        //          rst rdy stl br bt            jp jt            ex  en addr          req fv pc            epc   st
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h00400000, 0, 0, 32'h12345678, 32'h0, 2'd0)); // v0 reset
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h00400000, 0, 0, 32'h12345678, 32'h0, 2'd0)); // v1 boot
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h00400004, 1, 1, 32'h00400000, 32'h0, 2'd1)); // v2
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h00400008, 1, 1, 32'h00400004, 32'h0, 2'd1)); // v3
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        1, 1, 32'h00400008, 32'h0, 2'd1)); // v4 stall
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0, 0, 32'h00400008, 32'h0, 2'd2)); // v5 hold
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0, 0, 32'h00400008, 32'h0, 2'd2)); // v6
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0, 0, 32'h00400008, 32'h0, 2'd2)); // v7
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0040000C, 0, 0, 32'h00400008, 32'h0, 2'd2)); // v8 release
        tbl.push_back(mk(0, 0, 0, 1, 32'h00400102, 0, 32'h0,        0,  0, 32'h0,        1, 0, 32'h0040000C, 32'h0, 2'd1)); // v9 branch waiting
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        1, 0, 32'h0040000C, 32'h0, 2'd1)); // v10
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h00400100, 1, 0, 32'h0040000C, 32'h0, 2'd1)); // v11 pending used
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h00400104, 1, 1, 32'h00400100, 32'h0, 2'd1)); // v12 pending gone
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h0040000C, 0,  1, 32'h0040000C, 1, 0, 32'h00400104, 32'h0, 2'd1)); // v13 jump
        tbl.push_back(mk(0, 1, 0, 1, 32'h00400300, 1, 32'h00400200, 1,  1, 32'h80000180, 1, 0, 32'h0040000C, 32'h0, 2'd1)); // v14 all three
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h80000184, 1, 1, 32'h80000180, EPC1,  2'd1)); // v15
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 0, 32'h80000184, EPC1,  2'd1)); // v16 exc waiting
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h00400200, 0,  0, 32'h0,        1, 0, 32'h80000184, EPC2,  2'd1)); // v17 jump vs pend exc
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h80000180, 1, 0, 32'h80000184, EPC2,  2'd1)); // v18 exc kept
        tbl.push_back(mk(0, 1, 0, 1, 32'h00400300, 1, 32'h00400203, 0,  1, 32'h00400200, 1, 0, 32'h80000180, EPC2,  2'd1)); // v19 jump > branch
        tbl.push_back(mk(0, 1, 0, 1, 32'h00400311, 0, 32'h0,        0,  1, 32'h00400310, 1, 0, 32'h00400200, EPC2,  2'd1)); // v20 align
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        1, 1, 32'h00400310, EPC2,  2'd1)); // v21 stall
        tbl.push_back(mk(0, 0, 1, 1, 32'h00400500, 0, 32'h0,        0,  1, 32'h00400500, 0, 0, 32'h00400310, EPC2,  2'd2)); // v22 redirect in hold
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h00400504, 1, 1, 32'h00400500, EPC2,  2'd1)); // v23

        // First rising edge happens with reset high before the table starts.
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec($sformatf("v%0d", i), tbl[i]);
        end

        // Wrap-around: park PC at the top of the address space.
        @(negedge clock);
        force_pc          = 1'b1;
        force_val         = 32'hFFFF_FFFC;
        bus.imem_ready    = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.jump          = 1'b0;
        bus.exception     = 1'b0;
        run_vec("wrap",  mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h00000000, 1, 1, 32'hFFFFFFFC, EPC2,  2'd1));
        // Stall into HOLD, then reset while holding.
        run_vec("w_stl", mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,        1, 1, 32'h00000000, EPC2,  2'd1));
        run_vec("w_rst", mk(1, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h00400000, 0, 0, 32'h00000000, EPC2,  2'd2));
        run_vec("w_bt",  mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h00400000, 0, 0, 32'h00000000, 32'h0, 2'd0));
        run_vec("w_req", mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,        1, 0, 32'h00400000, 32'h0, 2'd1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
